// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM encoding and board defaults.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // One-second gate on the 100 MHz board clock.
    localparam int DEFAULT_GATE_CYCLES = 100_000_000;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input and flags its rising edges in the clk domain.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchronizer chain followed by a one-cycle history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clocks and latches the result.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int                GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_s;
    logic              launch_s;
    logic              rise_s;
    logic [GW-1:0]     gate_cnt_r;
    logic [CNT_W-1:0]  edge_cnt_r;
    logic              sat_r;
    logic [CNT_W-1:0]  freq_r;
    logic              freq_valid_r;
    logic              busy_r;
    logic              overflow_r;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(sig_in),
        .rise    (rise_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; launch_s marks every entry into a fresh window.
    always_comb begin
        state_s  = state_r;
        launch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start || continuous) begin
                    state_s  = GATE;
                    launch_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            GATE: begin
                if (gate_cnt_r == GATE_LAST) begin
                    state_s = LATCH;
                end else begin
                    state_s = GATE;
                end
            end
            LATCH: begin
                if (start || continuous) begin
                    state_s  = GATE;
                    launch_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Gate and edge counters; sat records a rise lost at full scale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
            sat_r      <= 1'b0;
        end else if (launch_s) begin
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
            sat_r      <= 1'b0;
        end else if (state_r == GATE) begin
            if (gate_cnt_r != GATE_LAST) begin
                gate_cnt_r <= gate_cnt_r + GW'(1);
            end else begin
                gate_cnt_r <= gate_cnt_r;
            end
            if (rise_s && (edge_cnt_r == CNT_MAX)) begin
                sat_r <= 1'b1;
            end else if (rise_s) begin
                edge_cnt_r <= edge_cnt_r + CNT_W'(1);
            end else begin
                edge_cnt_r <= edge_cnt_r;
            end
        end else begin
            gate_cnt_r <= gate_cnt_r;
        end
    end

    // Registered outputs; the result is published on the edge that ends LATCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freq_r       <= '0;
            freq_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            freq_valid_r <= (state_r == LATCH);
            busy_r       <= (state_s == GATE);
            if (state_r == LATCH) begin
                freq_r     <= edge_cnt_r;
                overflow_r <= sat_r;
            end else begin
                freq_r     <= freq_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign freq       = freq_r;
    assign freq_valid = freq_valid_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

endmodule
